vx_fetch_arb: RTL and testbench

//  Per-core fetch arbiter between the warp scheduler and the icache request port.
//  - Picks one eligible warp per issue slot with round-robin priority.
//  - Presents that warp's PC to the icache as a valid/ready request.
//  - Allows at most one in-flight fetch per warp and caps total outstanding fetches with a credit counter.
//  - Drives the fetch busy indication.

---
 rtl/vx_fetch_arb_pkg.sv | 26 ++
 rtl/vx_fetch_arb_rr_picker.sv | 32 +++
 rtl/vx_fetch_arb.sv | 163 ++++++++++++++++
 tb/tb_vx_fetch_arb.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_fetch_arb_pkg.sv
// Shared fetch-path types: FSM state encoding, warp-id width and the request record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package VX_fetch_pkg;

   // Core build configuration the fetch path is sized for.
   localparam int VX_NUM_WARPS = 4;
   localparam int VX_PC_WIDTH  = 32;
   localparam int NW_BITS      = $clog2(VX_NUM_WARPS);

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [NW_BITS-1:0]     wid;
      logic [VX_PC_WIDTH-1:0] pc;
   } fetch_req_t;

   // Next round-robin start point: one past the warp that just issued, wrapping.
   function automatic logic [NW_BITS-1:0] wid_inc(input logic [NW_BITS-1:0] w);
      return w + NW_BITS'(1);
   endfunction

endpackage

// File: rtl/vx_fetch_arb_rr_picker.sv
// Round-robin picker: lowest eligible index at or above rr_ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to act on the pick.
module vx_rr_picker
   import VX_fetch_pkg::*;
#(
   parameter int N = VX_NUM_WARPS,
   parameter int W = $clog2(N)
)(
   input  logic [N-1:0] eligible,
   input  logic [W-1:0] rr_ptr,
   output logic         found,
   output logic [W-1:0] wid
);

   logic [W-1:0] idx;

   // Scan N positions starting at rr_ptr; index arithmetic wraps naturally since N is 2^W.
   always_comb begin
      found = 1'b0;
      wid   = '0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = rr_ptr + W'(i);
         if (!found && eligible[idx]) begin
            found = 1'b1;
            wid   = idx;
         end
      end
   end

endmodule

// File: rtl/vx_fetch_arb.sv
// Per-core fetch arbiter: round-robin pick of an eligible warp, one registered icache request at a time.
// Latency: request appears one cycle after eligibility; at most one issue every two cycles.
// Backpressure: request held stable until req_ready; credits cap outstanding fetches, one in flight per warp.
// Optional build macro VX_FETCH_ARB_PERF_EN enables the perf_stalls / perf_issued counters.
module vx_fetch_arb
   import VX_fetch_pkg::*;
#(
   parameter int NUM_WARPS       = VX_NUM_WARPS,
   parameter int MAX_OUTSTANDING = 4,
   parameter int PC_WIDTH        = VX_PC_WIDTH
)(
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_WARPS-1:0]          warp_active,
   input  logic [NUM_WARPS-1:0]          warp_stall,
   input  logic [NUM_WARPS*PC_WIDTH-1:0] warp_pc,
   input  logic                          flush,
   output logic                          req_valid,
   output logic [$clog2(NUM_WARPS)-1:0]  req_wid,
   output logic [PC_WIDTH-1:0]           req_pc,
   input  logic                          req_ready,
   input  logic                          rsp_valid,
   input  logic [$clog2(NUM_WARPS)-1:0]  rsp_wid,
   output logic [31:0]                   perf_stalls,
   output logic [31:0]                   perf_issued,
   output logic                          busy
);

   localparam int WB = $clog2(NUM_WARPS);
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CW-1:0] CRED_MAX = CW'(MAX_OUTSTANDING);

   fetch_state_e         state;
   fetch_req_t           req_q;
   logic [WB-1:0]        rr_ptr;
   logic [NUM_WARPS-1:0] inflight;
   logic [CW-1:0]        credits;

   logic [NUM_WARPS-1:0] eligible;
   logic                 issue_ok;
   logic                 pick_found;
   logic [WB-1:0]        pick_wid;
   logic [PC_WIDTH-1:0]  pick_pc;
   logic                 fire;
   logic                 rsp_ok;
   logic [NUM_WARPS-1:0] set_mask;
   logic [NUM_WARPS-1:0] clr_mask;

   // A warp competes only if enabled, not stalled and with no fetch already outstanding.
   assign eligible = warp_active & ~warp_stall & ~inflight;
   assign issue_ok = (credits < CRED_MAX);

   vx_rr_picker #(
      .N (NUM_WARPS),
      .W (WB)
   ) u_picker (
      .eligible (eligible),
      .rr_ptr   (rr_ptr),
      .found    (pick_found),
      .wid      (pick_wid)
   );

   assign pick_pc = warp_pc[pick_wid*PC_WIDTH +: PC_WIDTH];

   // req_valid is only ever set in REQ, so the handshake needs no state qualifier.
   assign fire = req_valid & req_ready;

   // Responses for warps with nothing in flight (e.g. stale after reset) must not touch credits.
   assign rsp_ok = rsp_valid & inflight[rsp_wid];

   assign set_mask = fire   ? (NUM_WARPS'(1) << req_q.wid) : '0;
   assign clr_mask = rsp_ok ? (NUM_WARPS'(1) << rsp_wid)   : '0;

   assign req_wid = req_q.wid;
   assign req_pc  = req_q.pc;
   assign busy    = req_valid | (credits != '0);

   // Request FSM: capture a pick in IDLE, hold it in REQ until accepted or flushed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         req_valid <= 1'b0;
         req_q     <= '0;
         rr_ptr    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found && issue_ok) begin
                  req_q.wid <= pick_wid;
                  req_q.pc  <= pick_pc;
                  req_valid <= 1'b1;
                  state     <= REQ;
               end
            end
            REQ: begin
               // A same-cycle handshake takes priority over flush.
               if (req_ready) begin
                  req_valid <= 1'b0;
                  rr_ptr    <= wid_inc(req_q.wid);
                  state     <= IDLE;
               end else if (flush) begin
                  req_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               req_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   // In-flight bookkeeping: issue sets a warp bit, response clears it; credits track the population.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight <= '0;
         credits  <= '0;
      end else begin
         inflight <= (inflight | set_mask) & ~clr_mask;
         case ({fire, rsp_ok})
            2'b10:   credits <= credits + CW'(1);
            2'b01:   credits <= credits - CW'(1);
            default: credits <= credits;
         endcase
      end
   end

`ifdef VX_FETCH_ARB_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] issue_cnt;

   // Free-running event counters; wrap at 2^32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
         issue_cnt <= '0;
      end else begin
         if (req_valid && !req_ready) stall_cnt <= stall_cnt + 32'd1;
         if (fire)                    issue_cnt <= issue_cnt + 32'd1;
      end
   end

   assign perf_stalls = stall_cnt;
   assign perf_issued = issue_cnt;
`else
   assign perf_stalls = '0;
   assign perf_issued = '0;
`endif

   // A response must always match an outstanding fetch.
   a_rsp_matches_inflight: assert property (
      @(posedge clk) disable iff (reset) rsp_valid |-> inflight[rsp_wid]);

   // The credit counter stays within its legal range.
   a_credits_bounded: assert property (
      @(posedge clk) disable iff (reset) credits <= CRED_MAX);

   // Credits equal the number of warps with a fetch in flight.
   a_credits_match_inflight: assert property (
      @(posedge clk) disable iff (reset) 32'(credits) == $countones(inflight));

endmodule

// File: tb/tb_vx_fetch_arb.sv
// Bench for vx_fetch_arb with MAX_OUTSTANDING=2: directed phases feed a scoreboard of
// expected (wid, pc) issues; a forked monitor pops and compares on every accepted request.
// Perf counter expectations follow the VX_FETCH_ARB_PERF_EN build macro.
module tb_vx_fetch_arb;

   localparam int NW   = 4;
   localparam int PCW  = 32;
   localparam int MAXO = 2;

`ifdef VX_FETCH_ARB_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic [NW-1:0]     warp_active;
   logic [NW-1:0]     warp_stall;
   logic [NW*PCW-1:0] warp_pc;
   logic              flush;
   logic              req_valid;
   logic [1:0]        req_wid;
   logic [PCW-1:0]    req_pc;
   logic              req_ready;
   logic              rsp_valid;
   logic [1:0]        rsp_wid;
   logic [31:0]       perf_stalls;
   logic [31:0]       perf_issued;
   logic              busy;

   vx_fetch_arb #(
      .NUM_WARPS       (NW),
      .MAX_OUTSTANDING (MAXO),
      .PC_WIDTH        (PCW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .warp_active (warp_active),
      .warp_stall  (warp_stall),
      .warp_pc     (warp_pc),
      .flush       (flush),
      .req_valid   (req_valid),
      .req_wid     (req_wid),
      .req_pc      (req_pc),
      .req_ready   (req_ready),
      .rsp_valid   (rsp_valid),
      .rsp_wid     (rsp_wid),
      .perf_stalls (perf_stalls),
      .perf_issued (perf_issued),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_vec   = 0;
   int         n_bad   = 0;
   int         acc_cnt = 0;
   bit         auto_rsp = 1'b0;
   logic [1:0] exp_wid [$];
   logic [31:0] exp_pc [$];
   int         due_q   [$];
   logic [1:0] due_wid [$];

   function automatic logic [31:0] pc_of(input int w);
      return 32'h8000_1000 + 32'(w) * 32'h0000_0104;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic expect_req(input int w);
      exp_wid.push_back(2'(w));
      exp_pc.push_back(pc_of(w));
   endtask

   // Advance one cycle; inputs change 1 time unit after the edge. Auto responses fire here.
   task automatic step();
      @(posedge clk);
      #1;
      rsp_valid = 1'b0;
      if (auto_rsp && due_q.size() > 0 && due_q[0] <= cyc + 1) begin
         rsp_valid = 1'b1;
         rsp_wid   = due_wid.pop_front();
         void'(due_q.pop_front());
      end
   endtask

   task automatic monitor();
      forever begin
         @(negedge clk);
         if (!reset && req_valid && req_ready) begin
            chk("sb_exp_avail", 64'(exp_wid.size() > 0), 64'd1);
            if (exp_wid.size() > 0) begin
               chk("sb_wid", 64'(req_wid), 64'(exp_wid.pop_front()));
               chk("sb_pc",  64'(req_pc),  64'(exp_pc.pop_front()));
            end
            acc_cnt++;
            if (auto_rsp) begin
               due_q.push_back(cyc + 4);
               due_wid.push_back(req_wid);
            end
         end
      end
   endtask

   task automatic wait_acc(input int target, input string nm);
      int n = 0;
      while (acc_cnt < target && n < 200) begin
         step();
         n++;
      end
      chk(nm, 64'(acc_cnt >= target), 64'd1);
   endtask

   task automatic wait_valid(input string nm);
      int n = 0;
      while (!req_valid && n < 50) begin
         step();
         n++;
      end
      chk(nm, 64'(req_valid), 64'd1);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (busy && n < 100) begin
         step();
         n++;
      end
      chk(nm, 64'(busy), 64'd0);
   endtask

   initial begin
      int base;
      reset       = 1'b1;
      warp_active = '0;
      warp_stall  = '0;
      flush       = 1'b0;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      rsp_wid     = '0;
      for (int w = 0; w < NW; w++) warp_pc[w*PCW +: PCW] = pc_of(w);

      fork
         monitor();
      join_none

      // Reset state
      #1;
      chk("rst_req_valid", 64'(req_valid), 64'd0);
      chk("rst_req_wid",   64'(req_wid),   64'd0);
      chk("rst_req_pc",    64'(req_pc),    64'd0);
      chk("rst_busy",      64'(busy),      64'd0);
      chk("rst_perf_issued", 64'(perf_issued), 64'd0);
      step();
      step();
      reset = 1'b0;

      // Phase 1: all warps active, responses 3 cycles after acceptance -> 0,1,2,3,0
      for (int i = 0; i < 5; i++) expect_req(i % NW);
      auto_rsp    = 1'b1;
      req_ready   = 1'b1;
      warp_active = 4'hF;
      wait_acc(5, "t1_five_issued");
      warp_active = '0;
      wait_idle("t1_drain");

      // Phase 2: warp 2 held with req_ready=0 for 5 cycles
      req_ready   = 1'b0;
      warp_active = 4'b0100;
      expect_req(2);
      wait_valid("t2_valid");
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_valid", 64'(req_valid), 64'd1);
         chk("t2_hold_wid",   64'(req_wid),   64'd2);
         chk("t2_hold_pc",    64'(req_pc),    64'(pc_of(2)));
         step();
      end
      chk("t2_perf_stalls", 64'(perf_stalls), PERF ? 64'd5 : 64'd0);
      req_ready = 1'b1;
      step();
      warp_active = '0;
      chk("t2_perf_issued", 64'(perf_issued), PERF ? 64'd6 : 64'd0);
      wait_idle("t2_drain");

      // Phase 3: credit cap of 2 with warp 2 still eligible, no responses
      auto_rsp    = 1'b0;
      base        = acc_cnt;
      warp_active = 4'b0111;
      expect_req(0);
      expect_req(1);
      wait_acc(base + 2, "t3_two_issued");
      req_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t3_capped_valid", 64'(req_valid), 64'd0);
         chk("t3_capped_busy",  64'(busy),      64'd1);
      end
      chk("t3_exactly_two", 64'(acc_cnt - base), 64'd2);
      rsp_valid = 1'b1;
      rsp_wid   = 2'd0;
      expect_req(2);
      step();
      chk("t3_no_repick_same_cycle", 64'(req_valid), 64'd0);
      step();
      chk("t3_next_pick_valid", 64'(req_valid), 64'd1);
      chk("t3_next_pick_wid",   64'(req_wid),   64'd2);

      // Phase 4: accept warp 2 while warp 1 responds (credits stay 1)
      req_ready = 1'b1;
      rsp_valid = 1'b1;
      rsp_wid   = 2'd1;
      expect_req(0);
      step();
      step();
      chk("t4_swap_pick_valid", 64'(req_valid), 64'd1);
      chk("t4_swap_pick_wid",   64'(req_wid),   64'd0);
      step();
      for (int i = 0; i < 3; i++) begin
         chk("t4_cap_valid", 64'(req_valid), 64'd0);
         step();
      end
      warp_active = '0;
      rsp_valid = 1'b1;
      rsp_wid   = 2'd0;
      step();
      rsp_valid = 1'b1;
      rsp_wid   = 2'd2;
      step();
      step();
      chk("t4_drain_busy", 64'(busy), 64'd0);

      // Phase 5: flush with and without req_ready
      req_ready   = 1'b0;
      warp_active = 4'b0010;
      wait_valid("t5_valid");
      chk("t5_wid", 64'(req_wid), 64'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("t5_flush_drop_valid", 64'(req_valid), 64'd0);
      chk("t5_flush_drop_busy",  64'(busy),      64'd0);
      wait_valid("t5_valid_again");
      expect_req(1);
      flush     = 1'b1;
      req_ready = 1'b1;
      step();
      flush       = 1'b0;
      req_ready   = 1'b0;
      warp_active = '0;
      chk("t5_flush_vs_ready_busy", 64'(busy), 64'd1);
      chk("t5_perf_issued", 64'(perf_issued), PERF ? 64'd11 : 64'd0);

      // Phase 6: asynchronous reset with warp 1 in flight and warp 0 pending
      warp_active = 4'b0001;
      wait_valid("t6_pending");
      chk("t6_pending_wid", 64'(req_wid), 64'd0);
      reset = 1'b1;
      #1;
      chk("t6_async_valid", 64'(req_valid), 64'd0);
      chk("t6_async_wid",   64'(req_wid),   64'd0);
      chk("t6_async_pc",    64'(req_pc),    64'd0);
      chk("t6_async_busy",  64'(busy),      64'd0);
      chk("t6_async_perf",  64'(perf_issued | perf_stalls), 64'd0);
      rsp_valid = 1'b1;
      rsp_wid   = 2'd1;
      step();
      step();
      reset       = 1'b0;
      warp_active = 4'hF;
      req_ready   = 1'b1;
      base        = acc_cnt;
      expect_req(0);
      expect_req(1);
      wait_acc(base + 2, "t6_reissue");
      req_ready = 1'b0;
      step();
      chk("t6_cap_after_reset_valid", 64'(req_valid), 64'd0);
      chk("t6_cap_after_reset_busy",  64'(busy),      64'd1);
      chk("sb_drained", 64'(exp_wid.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
